// File: rtl/spn_cu_pkg.sv
// Shared types and helpers for the SPN round controller: FSM state encoding,
// block width and the round-key slicing function.
package spn_cu_pkg;

  typedef enum logic [2:0] {IDLE, WHITEN, ROUND, FINAL, DONE} spn_ctrl_state_t;

  localparam int unsigned SPN_BLK_W     = 16;
  localparam int unsigned SPN_KEY_W_MAX = 16 + 4 * 8;

  // Round key r is the 16-bit window starting 4*r bits below the key MSB.
  function automatic logic [SPN_BLK_W-1:0] spn_round_key(
    input logic [SPN_KEY_W_MAX-1:0] key,
    input int unsigned              key_w,
    input int unsigned              r
  );
    logic [SPN_KEY_W_MAX-1:0] sh;
    sh = key >> (key_w - SPN_BLK_W - 4 * r);
    return sh[SPN_BLK_W-1:0];
  endfunction

endpackage

// File: rtl/spn_key_sched.sv
// Combinational key slicer: selects round key K[idx] from the latched master key.
module spn_key_sched
  import spn_cu_pkg::*;
#(
  parameter  int unsigned ROUNDS = 4,
  localparam int unsigned KEY_W  = 16 + 4 * ROUNDS,
  localparam int unsigned IW     = $clog2(ROUNDS + 1)
) (
  input  logic [KEY_W-1:0]     key,
  input  logic [IW-1:0]        idx,
  output logic [SPN_BLK_W-1:0] round_key
);

  assign round_key = spn_round_key(SPN_KEY_W_MAX'(key), KEY_W, 32'(idx));

endmodule

// File: rtl/spn_round.sv
// Single combinational SPN round. Encrypt: P(S(d ^ k)); decrypt: S^-1(P(d)) ^ k.
// P is a 4x4 bit transpose, so it is its own inverse.
module spn_round (
  input  logic [15:0] data_in,
  input  logic [15:0] round_key,
  input  logic        mode,
  output logic [15:0] data_out
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  function automatic logic [15:0] sub(input logic [15:0] x, input logic inv);
    for (int unsigned n = 0; n < 4; n++)
      sub[4*n +: 4] = inv ? sbox_inv(x[4*n +: 4]) : sbox(x[4*n +: 4]);
  endfunction

  function automatic logic [15:0] perm(input logic [15:0] x);
    for (int unsigned i = 0; i < 16; i++)
      perm[4 * (i % 4) + i / 4] = x[i];
  endfunction

  always_comb begin
    data_out = '0;
    if (!mode) data_out = perm(sub(data_in ^ round_key, 1'b0));
    else       data_out = sub(perm(data_in), 1'b1) ^ round_key;
  end

endmodule

// File: rtl/spn_round_ctrl.sv
// Iterative SPN cipher controller around one spn_round instance with on-the-fly
// key schedule and key whitening. Optional `abort` port under SPN_CTRL_ABORT_EN.
module spn_round_ctrl
  import spn_cu_pkg::*;
#(
  parameter  int unsigned ROUNDS = 4,
  localparam int unsigned KEY_W  = 16 + 4 * ROUNDS,
  localparam int unsigned IW     = $clog2(ROUNDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SPN_BLK_W-1:0] data_in,
  input  logic [KEY_W-1:0]     key_in,
  input  logic                 mode,
`ifdef SPN_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SPN_BLK_W-1:0] data_out,
  output logic                 busy,
  output logic [IW-1:0]        round_idx
);

  spn_ctrl_state_t      fsm;
  logic [SPN_BLK_W-1:0] state;
  logic [KEY_W-1:0]     key_q;
  logic                 mode_q;
  logic [IW-1:0]        cnt;
  logic [SPN_BLK_W-1:0] rk;
  logic [SPN_BLK_W-1:0] rnd_out;

  // cnt always holds the index of the key in use, so it doubles as round_idx.
  assign round_idx = cnt;

  spn_key_sched #(.ROUNDS(ROUNDS)) u_key_sched (
    .key       (key_q),
    .idx       (cnt),
    .round_key (rk)
  );

  spn_round u_round (
    .data_in   (state),
    .round_key (rk),
    .mode      (mode_q),
    .data_out  (rnd_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state     <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
      cnt       <= '0;
      data_out  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state    <= data_in;
          key_q    <= key_in;
          mode_q   <= mode;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (mode) begin
            fsm <= WHITEN;
            cnt <= IW'(ROUNDS);
          end else begin
            fsm <= ROUND;
            cnt <= '0;
          end
        end
        WHITEN: begin
          state <= state ^ rk;
          fsm   <= ROUND;
          cnt   <= IW'(ROUNDS - 1);
        end
        ROUND: begin
          state <= rnd_out;
          if (!mode_q) begin
            if (cnt == IW'(ROUNDS - 1)) begin
              fsm <= FINAL;
              cnt <= IW'(ROUNDS);
            end else begin
              cnt <= cnt + IW'(1);
            end
          end else if (cnt == '0) begin
            fsm       <= DONE;
            data_out  <= rnd_out;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - IW'(1);
          end
        end
        FINAL: begin
          data_out  <= state ^ rk;
          fsm       <= DONE;
          out_valid <= 1'b1;
          cnt       <= '0;
        end
        DONE: if (out_ready) begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          fsm       <= IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
`ifdef SPN_CTRL_ABORT_EN
      // Later assignments override the case arms, including any data_out load.
      if (abort && (fsm == WHITEN || fsm == ROUND || fsm == FINAL)) begin
        fsm       <= IDLE;
        cnt       <= '0;
        data_out  <= data_out;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
        busy      <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spn_round_ctrl.sv
// Directed testbench for spn_round_ctrl (ROUNDS=4) with a transaction-level model.
module tb_spn_round_ctrl;

  localparam int unsigned R  = 4;
  localparam int unsigned KW = 16 + 4 * R;
  localparam logic [63:0] SBOX_TAB = 64'hC56B90AD3EF84712;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [15:0]   data_in, data_out;
  logic [KW-1:0] key_in;
  logic [2:0]    round_idx;
`ifdef SPN_CTRL_ABORT_EN
  logic          abort;
`endif

  int vectors = 0;
  int misses  = 0;

  always #5 clk = ~clk;

  spn_round_ctrl #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_in    (key_in),
    .mode      (mode),
`ifdef SPN_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy),
    .round_idx (round_idx)
  );

  // ---------------- reference cipher ----------------
  function automatic logic [3:0] m_sb(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX_TAB;
    return t[4 * (15 - int'(x)) +: 4];
  endfunction

  function automatic logic [3:0] m_isb(input logic [3:0] y);
    for (int v = 0; v < 16; v++)
      if (m_sb(4'(v)) == y) return 4'(v);
    return 4'h0;
  endfunction

  function automatic logic [15:0] m_key(input logic [KW-1:0] k, input int r);
    return k[KW - 1 - 4 * r -: 16];
  endfunction

  // Output nibble b collects bit b of every input nibble.
  function automatic logic [15:0] m_perm(input logic [15:0] x);
    logic [15:0] o;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++)
        o[4 * b + j] = x[4 * j + b];
    return o;
  endfunction

  function automatic logic [15:0] m_enc(input logic [15:0] d, input logic [KW-1:0] k);
    logic [15:0] s, t;
    s = d;
    for (int r = 0; r < int'(R); r++) begin
      s = s ^ m_key(k, r);
      for (int n = 0; n < 4; n++) t[4 * n +: 4] = m_sb(s[4 * n +: 4]);
      s = m_perm(t);
    end
    return s ^ m_key(k, R);
  endfunction

  function automatic logic [15:0] m_dec(input logic [15:0] d, input logic [KW-1:0] k);
    logic [15:0] s, t;
    s = d ^ m_key(k, R);
    for (int r = int'(R) - 1; r >= 0; r--) begin
      t = m_perm(s);
      for (int n = 0; n < 4; n++) s[4 * n +: 4] = m_isb(t[4 * n +: 4]);
      s = s ^ m_key(k, r);
    end
    return s;
  endfunction

  // ---------------- transaction model ----------------
  // q holds the round-key indices still to be applied; empty and not done = idle.
  int          q[$];
  bit          m_done = 1'b0;
  logic [15:0] m_out  = '0;
  logic [15:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    bit ab;
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
      m_out  = '0;
    end else begin
      ab = 1'b0;
`ifdef SPN_CTRL_ABORT_EN
      ab = abort;
`endif
      if (ab && q.size() > 0) begin
        q.delete();
      end else if (!m_done && q.size() == 0) begin
        if (in_valid) begin
          for (int i = 0; i <= int'(R); i++) q.push_back(mode ? int'(R) - i : i);
          m_pend = mode ? m_dec(data_in, key_in) : m_enc(data_in, key_in);
        end
      end else if (q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_done = 1'b1;
          m_out  = m_pend;
        end
      end else if (out_ready) begin
        m_done = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit idle;
    idle = !m_done && q.size() == 0;
    chk("in_ready",  32'(in_ready),  32'(idle));
    chk("busy",      32'(busy),      32'(!idle));
    chk("out_valid", 32'(out_valid), 32'(m_done));
    chk("round_idx", 32'(round_idx), q.size() > 0 ? 32'(q[0]) : 32'd0);
    chk("data_out",  32'(data_out),  32'(m_out));
  end

  // ---------------- stimulus ----------------
  int seen[$];

  task automatic timeout(input string nm);
    vectors++;
    misses++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic send(input logic m, input logic [15:0] d, input logic [KW-1:0] k);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; mode = m; data_in = d; key_in = k;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 50) begin timeout("accept"); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, input bit perturb);
    lat = 0;
    seen.delete();
    while (1) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      seen.push_back(int'(round_idx));
      if (perturb) begin
        data_in = 16'($urandom);
        key_in  = KW'($urandom);
        mode    = 1'($urandom);
      end
      lat++;
      if (lat > 50) begin timeout("out_valid"); break; end
    end
  endtask

  task automatic wait_idx2();
    int n;
    n = 0;
    while (round_idx !== 3'd2) begin
      @(negedge clk);
      n++;
      if (n > 50) begin timeout("round_idx==2"); break; end
    end
  endtask

  initial begin
    int            lat;
    logic [15:0]   ct, held;
    logic [KW-1:0] key1, key2;
    key1 = 32'hA5A5_3C3C;
    key2 = 32'h0F1E_2D3C;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
    data_in = '0; key_in = '0;
`ifdef SPN_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out",  32'(data_out),  32'h0000);
    chk("rst_busy",      32'(busy),      32'd0);
    #2 rst_n = 1'b1;

    // Hand-computed: 4 rounds of all-zero key on zero plaintext gives 4BCC.
    send(1'b0, 16'h0000, '0);
    wait_done(lat, 1'b0);
    chk("zero_enc_lat", 32'(lat), 32'd5);
    chk("zero_enc", 32'(data_out), 32'h4BCC);
    chk("model_zero_enc", 32'(m_enc(16'h0000, '0)), 32'h4BCC);
    send(1'b1, 16'h4BCC, '0);
    wait_done(lat, 1'b0);
    chk("zero_dec_lat", 32'(lat), 32'd5);
    chk("zero_dec", 32'(data_out), 32'h0000);

    // Round trip with index-sequence checks.
    send(1'b0, 16'h1234, key1);
    wait_done(lat, 1'b0);
    chk("enc_lat", 32'(lat), 32'd5);
    chk("enc_idx_len", 32'(seen.size()), 32'd5);
    foreach (seen[i]) chk("enc_idx", 32'(seen[i]), 32'(i));
    ct = data_out;
    chk("enc_ct", 32'(ct), 32'(m_enc(16'h1234, key1)));
    send(1'b1, ct, key1);
    wait_done(lat, 1'b0);
    chk("dec_lat", 32'(lat), 32'd5);
    chk("dec_idx_len", 32'(seen.size()), 32'd5);
    foreach (seen[i]) chk("dec_idx", 32'(seen[i]), 32'(4 - i));
    chk("round_trip", 32'(data_out), 32'h1234);

    // Inputs scrambled while busy must not affect the result.
    send(1'b0, 16'h1234, key1);
    wait_done(lat, 1'b1);
    chk("perturb_ct", 32'(data_out), 32'(ct));

    // Backpressure with a pending request held on the input.
    @(posedge clk); #1 out_ready = 1'b0;
    send(1'b0, 16'hBEEF, key2);
    wait_done(lat, 1'b0);
    held = m_enc(16'hBEEF, key2);
    @(posedge clk); #1;
    in_valid = 1'b1; mode = 1'b0; data_in = 16'h0F0F; key_in = key2;
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_data_out",  32'(data_out),  32'(held));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready",  32'(in_ready),  32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_busy",      32'(busy),      32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("next_accept_busy", 32'(busy), 32'd1);
    wait_done(lat, 1'b0);
    chk("bp_next_result", 32'(data_out), 32'(m_enc(16'h0F0F, key2)));

    // Reset in the middle of round 2.
    send(1'b0, 16'hCAFE, key1);
    wait_idx2();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_data_out",  32'(data_out),  32'h0000);
    #2 rst_n = 1'b1;

`ifdef SPN_CTRL_ABORT_EN
    send(1'b0, 16'h1234, key1);
    wait_done(lat, 1'b0);
    send(1'b0, 16'h5555, key1);
    wait_idx2();
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_data_out",  32'(data_out),  32'(ct));
`endif

    // Recovery after reset/abort.
    send(1'b1, ct, key1);
    wait_done(lat, 1'b0);
    chk("recover_dec", 32'(data_out), 32'h1234);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/spn_round_ctrl.md
# spn_round_ctrl

Iterative SPN cipher controller. It sequences the single-round `spn_round` datapath over `ROUNDS` rounds with an on-the-fly key schedule, and adds the final (encrypt) or initial (decrypt) key-whitening XOR. It exposes valid/ready handshakes on the plaintext/ciphertext input and the result output. The block sits between the host-side register/stream interface and the `spn_round` instance, which is the only SPN datapath in the unit.

## Interface
- `ROUNDS`, 4: number of substitution-permutation rounds (range 1–8).
- `KEY_W`, 16+4*ROUNDS: master key width (derived; do not override).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request; `data_in`, `key_in` and `mode` are valid.
- `in_ready`  out  1  high only in IDLE.
- `data_in`  in  16  plaintext (encrypt) or ciphertext (decrypt).
- `key_in`  in  KEY_W  master key.
- `mode`  in  1  0 = encrypt, 1 = decrypt.
- `out_valid`  out  1  `data_out` holds a finished block.
- `out_ready`  in  1  consumer accepts `data_out`.
- `data_out`  out  16  result register.
- `busy`  out  1  high in any state other than IDLE.
- `round_idx`  out  $clog2(ROUNDS+1)  index of the round key currently applied.

## Operation
- Round key r = `key_in[KEY_W-1-4r -: 16]`, for r = 0..ROUNDS. Keys are taken from the latched key register.
- On accept (`in_valid && in_ready`), latch `data_in` into `state`, `key_in` into `key_q`, and `mode` into `mode_q`. Later input changes are ignored.
- FSM states:
  - IDLE: waits for accept.
    - Encrypt: go to ROUND with cnt=0.
    - Decrypt: go to WHITEN.
  - WHITEN (decrypt only, one cycle): `state ^= K[ROUNDS]`. Go to ROUND with cnt=ROUNDS-1.
  - ROUND: `state <= spn_round.data_out`, using `round_key = K[cnt]` and `mode = mode_q`.
    - Encrypt: cnt counts up. After cnt=ROUNDS-1, go to FINAL.
    - Decrypt: cnt counts down. After cnt=0, go to DONE, loading `data_out`.
  - FINAL (encrypt only, one cycle): `data_out <= state ^ K[ROUNDS]`. Go to DONE.
  - DONE: `out_valid=1`. When `out_ready` is high, go to IDLE.
- `round_idx` = cnt in ROUND, ROUNDS in WHITEN/FINAL, and 0 otherwise.
- `data_out` holds its value until the next result is loaded.
- Boundaries:
  - `in_valid` during non-IDLE states is ignored and the stall is visible via `in_ready=0`.
  - DONE with `out_ready` high in the same cycle as a new `in_valid`: the new request is accepted only in the following IDLE cycle. There is no bypass.
  - ROUNDS=1: ROUND lasts exactly one cycle and the counter neither wraps nor underflows.
  - Reset mid-operation: return to IDLE immediately, and the partial result is discarded.

## Timing
- Reset values:
  - state = IDLE, `in_ready=1`, `out_valid=0`, `busy=0`.
  - `data_out=16'h0000`, `round_idx=0`, all internal registers 0.
- Accept at edge T0 → `out_valid` high after edge T0+ROUNDS+1 (5 cycles for ROUNDS=4), for both modes.
- `out_valid` stays high until the edge at which `out_ready` is sampled high. It falls at that edge, and `in_ready` rises at the same edge.
- Maximum throughput: one block per ROUNDS+3 cycles with `out_ready` tied high.
- `spn_round` is purely combinational. Its path is a single cycle, from the `state` register to the `state` register.

## Configuration
- `SPN_CTRL_ABORT_EN` defined: adds input port `abort` (1 bit).
  - `abort` sampled high in WHITEN, ROUND or FINAL: go to IDLE at that edge, with `out_valid` staying 0 and `data_out` unchanged.
  - `abort` in DONE or IDLE has no effect.
- `SPN_CTRL_ABORT_EN` undefined: the port does not exist and the FSM has no abort arcs.

## Structure
- `spn_cu_pkg` adds:
  - `typedef enum logic [2:0] {IDLE, WHITEN, ROUND, FINAL, DONE} spn_ctrl_state_t`;
  - `localparam SPN_BLK_W = 16`;
  - a function `spn_round_key(key, r)` implementing the key slice.
- Instantiates the existing `spn_round` (only `data_out` is used; debug taps are left unconnected).
- Natural sub-module: `spn_key_sched`, a combinational key slicer indexed by the round index.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles → `in_ready=1`, `out_valid=0`, `data_out=16'h0000`, `busy=0`.
- Round trip, ROUNDS=4:
  - Encrypt `data_in=16'h1234`, `key_in=32'hA5A5_3C3C` → `out_valid` exactly 5 cycles after accept.
  - Feed the ciphertext back with `mode=1` and the same key → `data_out=16'h1234`.
- Backpressure: hold `out_ready=0` for 10 cycles after the result → `out_valid`/`data_out` stable, `in_valid` ignored. Raising `out_ready` → next accept occurs one cycle later.
- Input changes after accept: toggle `data_in`/`key_in`/`mode` during ROUND → result identical to the unperturbed run.
- `round_idx` sequence: encrypt gives 0,1,2,3,4 (FINAL); decrypt gives 4 (WHITEN),3,2,1,0.
- Reset/abort mid-operation:
  - Assert `rst_n` low at round 2 → IDLE, `out_valid=0`.
  - With `SPN_CTRL_ABORT_EN`: pulse `abort` at round 2 → IDLE, `data_out` keeps its previous result.
